// File: rtl/sap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_pkg : opcodes, one-hot T-states and control-word type for sap_ctrl   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

  // High-actives at 0, low-actives at 1.
  localparam ctrl_word_t CW_IDLE = '{
    cp: 1'b0, ep: 1'b0, lm: 1'b1, ce: 1'b1, li: 1'b1, ei: 1'b1,
    la: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, lb: 1'b1, lo: 1'b1
  };

endpackage
`default_nettype wire

// File: rtl/sap_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_ctrl_if : opcode/step inputs and control-word outputs of sap_ctrl    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sap_ctrl_if #(
  parameter int OPC_W = 4
);
  logic [OPC_W-1:0] opcode;
  logic             step_en;
  logic             step;
  logic             cp;
  logic             ep;
  logic             lm;
  logic             ce;
  logic             li;
  logic             ei;
  logic             la;
  logic             ea;
  logic             su;
  logic             eu;
  logic             lb;
  logic             lo;
  logic             hlt;
  logic [5:0]       t_state;

  modport master (
    output opcode, step_en, step,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, t_state
  );

  modport slave (
    input  opcode, step_en, step,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, t_state
  );
endinterface
`default_nettype wire

// File: rtl/sap_ring_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_ring_counter : T1..T6 one-hot ring with free-run/step and HLT freeze |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sap_ring_counter
  import sap_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     clr,
  input  wire logic     step_en_i,
  input  wire logic     step_i,
  input  wire logic     hlt_op_i,
  output t_state_e      t_state_o,
  output logic          hlt_o
);

  t_state_e t_q;
  t_state_e t_d;
  logic     hlt_q;
  logic     adv;

  assign adv = ~step_en_i | step_i;

  always_comb begin
    t_d = T1;
    case (t_q)
      T1:      t_d = T2;
      T2:      t_d = T3;
      T3:      t_d = T4;
      T4:      t_d = T5;
      T5:      t_d = T6;
      default: t_d = T1;
    endcase
  end

  // HLT is taken on the edge that would leave T4, so the ring parks there.
  always_ff @(posedge clk) begin
    if (clr) begin
      t_q   <= T1;
      hlt_q <= 1'b0;
    end else if (adv && !hlt_q) begin
      if (t_q == T4 && hlt_op_i) begin
        hlt_q <= 1'b1;
      end else begin
        t_q <= t_d;
      end
    end
  end

  assign t_state_o = t_q;
  assign hlt_o     = hlt_q;

endmodule
`default_nettype wire

// File: rtl/sap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_ctrl : SAP controller-sequencer, ring counter plus control decode    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sap_ctrl
  import sap_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input wire logic  clk,
  input wire logic  clr,
  sap_ctrl_if.slave bus
);

  logic [OPC_W-1:0] opc;
  t_state_e         t_state;
  logic             hlt;
  ctrl_word_t       cw;

  assign opc = bus.opcode;

  sap_ring_counter u_ring (
    .clk       (clk),
    .clr       (clr),
    .step_en_i (bus.step_en),
    .step_i    (bus.step),
    .hlt_op_i  (opc == OPC_W'(OP_HLT)),
    .t_state_o (t_state),
    .hlt_o     (hlt)
  );

  // clr and halt both blank the control word without waiting for an edge.
  always_comb begin
    cw = CW_IDLE;
    if (!clr && !hlt) begin
      case (t_state)
        T1: begin
          cw.ep = 1'b1;
          cw.lm = 1'b0;
        end
        T2: cw.cp = 1'b1;
        T3: begin
          cw.ce = 1'b0;
          cw.li = 1'b0;
        end
        T4: begin
          case (opc)
            OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
              cw.lm = 1'b0;
              cw.ei = 1'b0;
            end
            OPC_W'(OP_OUT): begin
              cw.ea = 1'b1;
              cw.lo = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opc)
            OPC_W'(OP_LDA): begin
              cw.ce = 1'b0;
              cw.la = 1'b0;
            end
            OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
              cw.ce = 1'b0;
              cw.lb = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          if (opc == OPC_W'(OP_ADD) || opc == OPC_W'(OP_SUB)) begin
            cw.eu = 1'b1;
            cw.la = 1'b0;
            cw.su = (opc == OPC_W'(OP_SUB));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cp      = cw.cp;
  assign bus.ep      = cw.ep;
  assign bus.lm      = cw.lm;
  assign bus.ce      = cw.ce;
  assign bus.li      = cw.li;
  assign bus.ei      = cw.ei;
  assign bus.la      = cw.la;
  assign bus.ea      = cw.ea;
  assign bus.su      = cw.su;
  assign bus.eu      = cw.eu;
  assign bus.lb      = cw.lb;
  assign bus.lo      = cw.lo;
  assign bus.hlt     = hlt;
  assign bus.t_state = t_state;

endmodule
`default_nettype wire
